// File: rtl/adc_fe_pkg.sv
// Shared constants, FSM state types and the sample clamp for the ADC front end.
package adc_fe_pkg;

   localparam logic [7:0] EOF_CODE  = 8'hFF;
   localparam logic [7:0] CLAMP_MAX = 8'hFE;

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_SETUP = 2'd1,
      C_SHIFT = 2'd2,
      C_GAP   = 2'd3
   } cap_state_t;

   typedef enum logic [1:0] {
      S_WAIT    = 2'd0,
      S_STROBE  = 2'd1,
      S_RELEASE = 2'd2,
      S_END     = 2'd3
   } srv_state_t;

   // 0xFF on the data bus always means end-of-frame, so a real sample never carries it.
   function automatic logic [7:0] clamp_sample(input logic [7:0] s);
      return (s == EOF_CODE) ? CLAMP_MAX : s;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with full/empty flags, synchronous clear and show-ahead read.
module sample_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   // Extra pointer bit tells a wrapped-full buffer apart from an empty one.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/adc_frontend.sv
// Serial ADC sampler + FIFO + req/rdy server that ends each frame with 0xFF.
// Define ADC_FE_TESTPAT_EN to replace serial capture with an internal ramp.
module adc_frontend
   import adc_fe_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int CONV_GAP   = 2,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] len,
   input  logic       req,
   output logic [7:0] dat,
   output logic       rdy,
   output logic       busy,
   output logic       frame_done,
   output logic       adc_cs_n,
   output logic       adc_sclk,
   input  logic       adc_miso
);

   localparam int TMAX = (CLK_DIV > CONV_GAP) ? CLK_DIV : CONV_GAP;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] DIV_LAST = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] GAP_LAST = TW'(CONV_GAP - 1);

   cap_state_t cap_state;
   srv_state_t srv_state;
   logic [TW-1:0] tmr;
   logic [3:0]    half;
   logic [7:0]    sh, ramp, len_q, cap_cnt, dlv_cnt;
   logic          cs_q, sclk_q, eof_q;
   logic          start_acc, push, pop, full, empty;
   logic [7:0]    push_dat, fifo_dout;

   assign start_acc = start && !busy;
   assign push      = (cap_state == C_SHIFT) && (tmr == DIV_LAST) && (half == 4'd15);
   assign pop       = (srv_state == S_WAIT) && req && !empty;

`ifdef ADC_FE_TESTPAT_EN
   assign push_dat = clamp_sample(ramp);
   assign adc_cs_n = 1'b1;
   assign adc_sclk = 1'b0;
`else
   assign push_dat = clamp_sample(sh);
   assign adc_cs_n = cs_q;
   assign adc_sclk = sclk_q;
`endif

   sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_acc),
      .push  (push),
      .din   (push_dat),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty)
   );

   // Capture: one conversion slot per sample, never started without FIFO room.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_state <= C_IDLE;
         tmr       <= '0;
         half      <= '0;
         sh        <= '0;
         ramp      <= '0;
         cap_cnt   <= '0;
         cs_q      <= 1'b1;
         sclk_q    <= 1'b0;
      end else begin
         case (cap_state)
            C_IDLE: begin
               if (busy && (cap_cnt < len_q) && !full) begin
                  cap_state <= C_SETUP;
                  tmr       <= '0;
                  cs_q      <= 1'b0;
               end
            end
            C_SETUP: begin
               if (tmr == DIV_LAST) begin
                  cap_state <= C_SHIFT;
                  tmr       <= '0;
                  half      <= '0;
                  sclk_q    <= 1'b1;
                  sh        <= {sh[6:0], adc_miso};
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            C_SHIFT: begin
               if (tmr == DIV_LAST) begin
                  tmr <= '0;
                  if (half == 4'd15) begin
                     cap_state <= C_GAP;
                     cs_q      <= 1'b1;
                     sclk_q    <= 1'b0;
                     cap_cnt   <= cap_cnt + 1'b1;
                     ramp      <= ramp + 1'b1;
                  end else begin
                     half   <= half + 1'b1;
                     sclk_q <= ~sclk_q;
                     // Sample on the low-to-high sclk transition.
                     if (!sclk_q) sh <= {sh[6:0], adc_miso};
                  end
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            default: begin
               if (tmr == GAP_LAST) begin
                  cap_state <= C_IDLE;
                  tmr       <= '0;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
         endcase
         if (start_acc) begin
            cap_cnt <= '0;
            ramp    <= '0;
         end
      end
   end

   // Serve: one strobe per req, released only after req drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         srv_state  <= S_WAIT;
         dat        <= '0;
         rdy        <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         eof_q      <= 1'b0;
         len_q      <= '0;
         dlv_cnt    <= '0;
      end else begin
         case (srv_state)
            S_WAIT: begin
               if (pop) begin
                  srv_state <= S_STROBE;
                  dat       <= fifo_dout;
                  rdy       <= 1'b1;
                  eof_q     <= 1'b0;
                  dlv_cnt   <= dlv_cnt + 1'b1;
               end else if (req && busy && (dlv_cnt == len_q)) begin
                  srv_state <= S_STROBE;
                  dat       <= EOF_CODE;
                  rdy       <= 1'b1;
                  eof_q     <= 1'b1;
               end
            end
            S_STROBE: begin
               rdy <= 1'b0;
               if (eof_q) begin
                  srv_state  <= S_END;
                  frame_done <= 1'b1;
               end else begin
                  srv_state <= S_RELEASE;
               end
            end
            S_END: begin
               srv_state  <= S_RELEASE;
               frame_done <= 1'b0;
               busy       <= 1'b0;
               eof_q      <= 1'b0;
            end
            default: begin
               if (!req) srv_state <= S_WAIT;
            end
         endcase
         if (start_acc) begin
            busy    <= 1'b1;
            len_q   <= len;
            dlv_cnt <= '0;
         end
      end
   end

endmodule

// File: doc/adc_frontend.md
# adc_frontend

Sample-source stage upstream of the smoothing filter. Drives an 8-bit serial ADC, buffers captured samples in a small FIFO, and delivers them one at a time over the filter's `req`/`rdy`/`dat` handshake. After `len` samples it sends the end-of-frame code 0xFF. It is the only producer on the filter's `dat`/`rdy` inputs.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `adc_sclk` half-period (≥2).
- `CONV_GAP`, default 2: `clk` cycles `adc_cs_n` stays high between conversions (≥1).
- `FIFO_DEPTH`, default 8: sample buffer entries, power of two.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle frame start; ignored while `busy`.
- `len`  in  8  samples per frame; latched on accepted `start`.
- `req`  in  1  consumer request, level.
- `dat`  out  8  sample or 0xFF end-of-frame code; valid while `rdy`.
- `rdy`  out  1  one-cycle data strobe.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse in the cycle after the 0xFF strobe.
- `adc_cs_n`  out  1  ADC chip select, active low.
- `adc_sclk`  out  1  ADC serial clock; idles low.
- `adc_miso`  in  1  ADC serial data, MSB first.

## Operation
- Reset values: `dat`=0, `rdy`=0, `busy`=0, `frame_done`=0, `adc_cs_n`=1, `adc_sclk`=0. FIFO empty, counters zero, both FSMs idle.
- Accepted `start` (`start`=1 and `busy`=0): latch `len`, clear the captured and delivered counters, set `busy` next cycle.
- Capture FSM states:
  - C_IDLE: go to C_SETUP when `busy`, captured < `len`, and FIFO not full. Otherwise stay, with `adc_cs_n`=1.
  - C_SETUP: `adc_cs_n`=0, `adc_sclk`=0, for `CLK_DIV` cycles, then C_SHIFT.
  - C_SHIFT: 16 half-periods of `CLK_DIV` cycles, starting with `adc_sclk` high. Sample `adc_miso` into a shift register on each rising `adc_sclk` transition. After the 16th half-period, push the sample and go to C_GAP.
  - C_GAP: `adc_cs_n`=1 for `CONV_GAP` cycles, then C_IDLE.
  - Per sample: 17·`CLK_DIV` + `CONV_GAP` cycles, plus 1 idle cycle.
- Clamp: a raw 0xFF is stored as 0xFE, because 0xFF is reserved for end-of-frame.
- FIFO full: no new conversion starts. A conversion already in progress is never started when full, so samples are never dropped.
- Serve FSM states:
  - S_WAIT: on `req`=1 with FIFO non-empty, pop and go to S_STROBE. If delivered == `len` and `busy`, go to S_STROBE with `dat`=0xFF instead.
  - S_STROBE: `rdy`=1 for exactly one cycle. Go to S_RELEASE, or S_END after the 0xFF strobe.
  - S_RELEASE: wait for `req`=0, then S_WAIT.
  - S_END: clear `busy`, pulse `frame_done`, then S_RELEASE.
- `len`=0: no conversion is started; the first strobe carries 0xFF.
- `dat` holds its last value after `rdy` falls.

## Timing
- `rdy` rises in the cycle after `req` is sampled high with data available (1-cycle latency).
- Minimum spacing between strobes: 2 cycles plus the consumer's `req` low time.
- Simultaneous FIFO push and pop in one cycle is legal; occupancy is unchanged.
- `rst` mid-frame: every register returns to its reset value on that edge. The FIFO is flushed and any partial sample is discarded.

## Configuration
- `ADC_FE_TESTPAT_EN` defined: the serial capture path is replaced by an internal 8-bit ramp.
  - The ramp starts at 0x00 on each accepted `start` and increments once per conversion slot.
  - Conversion-slot timing and the clamp are unchanged.
  - `adc_cs_n` stays 1, `adc_sclk` stays 0, and `adc_miso` is ignored.
- Undefined: serial ADC capture as described under Operation.

## Structure
- Package `adc_fe_pkg`:
  - `EOF_CODE`=8'hFF, `CLAMP_MAX`=8'hFE.
  - `cap_state_t` and `srv_state_t` enums.
- Sub-module `sample_fifo`: synchronous FIFO, parameterised by depth, with `full`, `empty` and synchronous clear. The top level holds both FSMs and the SPI shifter.

## Test plan
- Basic frame: `len`=3, ADC model returns 0x12, 0x34, 0x56; consumer behaves like the filter → strobes 0x12, 0x34, 0x56, 0xFF, then one `frame_done` pulse, then `busy`=0.
- Clamp: ADC returns 0xFF, `len`=1 → strobes 0xFE, then 0xFF.
- Empty frame: `len`=0 → first strobe is 0xFF; `adc_cs_n` never goes low.
- Back-pressure: `len`=12, `req` held low until 8 samples are captured → `adc_cs_n` stays high with the FIFO full. After `req` is enabled, all 12 samples arrive in order, followed by 0xFF.
- Reset mid-shift: `rst` during C_SHIFT → next cycle `adc_cs_n`=1, `adc_sclk`=0, `busy`=0, `rdy`=0. A new `start` with `len`=2 then delivers fresh samples.
- Test pattern (`ADC_FE_TESTPAT_EN`): `len`=4 → strobes 0x00, 0x01, 0x02, 0x03, 0xFF.
